ext_target_unit: RTL and testbench
==================================

// Module: ext_target_unit
// PURPOSE
//  Parametrised operand-extension and branch/jump-target unit with a registered valid/ready output queue.
//  It takes an immediate, jump index, PC+4 and optionally a load word with a mode select.
//  It returns the extended operand or target address one cycle later.
//  It sits between the decode and the execute/PC-update states of the multicycle datapath.
// PARAMETERS
//  DATA_W  32  datapath width; must equal PC_HI_W+IDX_W+2 and be >= IMM_W+2
//  IMM_W   16  immediate/offset field width
//  IDX_W   26  jump index field width
//  PC_HI_W 4   PC+4 upper bits kept for jump targets
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous reset, active-high
//  in_valid     in   1        request present
//  in_ready     out  1        unit can accept; =!rst && count!=2
//  in_mode      in   4        operation (see BEHAVIOUR)
//  in_imm       in   IMM_W    immediate / branch offset
//  in_idx       in   IDX_W    jump index
//  in_pc        in   DATA_W   PC+4 of the instruction
//  in_word      in   DATA_W   aligned memory word (load modes)
//  in_addr_lo   in   2        byte address bits [1:0] (load modes)
//  out_valid    out  1        head entry valid
//  out_ready    in   1        consumer takes head
//  out_data     out  DATA_W   result
//  out_err      out  1        illegal mode / misaligned halfword
// BEHAVIOUR
//  - Transfer in: in_valid&&in_ready at edge; transfer out: out_valid&&out_ready at edge.
//  - Latency: request accepted at edge N is visible on out_data/out_valid after edge N (1 cycle) if queue was empty.
//  - 2-entry FIFO, count 0..2: push only, count+1; pop only, count-1; push+pop, count unchanged.
//    No push at count==2 because in_ready=0. Order is strictly FIFO.
//  - out_valid = count!=0. out_data/out_err show the head entry. Entries are stable while out_valid&&!out_ready.
//  - Modes:
//    - 0 ZEXT: zero-extend imm.
//    - 1 SEXT: sign-extend imm from bit IMM_W-1.
//    - 2 LUI: {imm, zeros}.
//    - 3 BR: in_pc + (sext(imm)<<2), mod 2^DATA_W, carry dropped.
//    - 4 JMP: {in_pc[DATA_W-1 -: PC_HI_W], idx, 2'b00}.
//    - 5 SHL2: zero-extend {imm,2'b00}.
//  - Any other mode: out_data=0, out_err=1 (entry is still queued, no stall).
//  - Reset: count=0, out_valid=0, out_data=0, out_err=0, in_ready=0 while rst=1.
//    Reset mid-operation discards queued entries. A request presented during rst is not accepted.
// CONFIGURATION
//  Macro EXT_TARGET_LOAD_EN adds these load modes, each byte/half selected by in_addr_lo:
//    - 8 LB: sign-extended byte.
//    - 9 LBU: zero-extended byte.
//    - 10 LH: sign-extended halfword.
//    - 11 LHU: zero-extended halfword.
//  Little-endian lanes: byte k = word[8k+7:8k]; half = addr_lo[1] ? word[31:16] : word[15:0].
//  LH/LHU with addr_lo[0]=1: out_data=0, out_err=1.
//  Without the macro, modes 8-11 are illegal (data 0, err 1) and in_word/in_addr_lo are unused.
// STRUCTURE
//  Package ext_pkg:
//    - MODE_W=4.
//    - Localparams MODE_ZEXT..MODE_LHU.
//    - FIFO_DEPTH=2.
//  Sub-module ext_calc: purely combinational mode mux/extender/adder, same parameters.
//  Top: ext_calc instance, 2-entry register queue (data+err), count, read/write pointers.
// TESTING
//  1. rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0, nothing queued after release.
//  2. SEXT imm=16'h8001 -> 32'hFFFF8001 next cycle.
//     ZEXT same imm -> 32'h00008001.
//     LUI 16'h1234 -> 32'h12340000.
//  3. BR pc=32'h0040_0010, imm=16'hFFFF -> 32'h0040_000C.
//     JMP pc=32'hA000_0004, idx=26'h0000100 -> 32'hA000_0400.
//  4. out_ready=0, push 3 back-to-back -> 2 accepted, in_ready=0 on third.
//     Head holds 1st result. Release out_ready -> results pop in order, no loss.
//  5. Count=1 with simultaneous push+pop each cycle for 10 cycles -> count stays 1, stream in order.
//     Mode 4'hF -> data 0, err 1.
//  6. (EXT_TARGET_LOAD_EN) word=32'h80FF_7F01:
//     - LB lo=2 -> 32'hFFFFFFFF.
//     - LBU lo=3 -> 32'h00000080.
//     - LH lo=2 -> 32'hFFFF80FF.
//     - LHU lo=1 -> err=1, data 0.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: shared constants for the operand-extension / target unit.
//   MODE_W      width of the mode select
//   MODE_*      operation codes; codes 8..11 are load-lane modes that only
//               exist when the unit is built with EXT_TARGET_LOAD_EN
//   FIFO_DEPTH  entries in the output queue
package ext_pkg;

    localparam int MODE_W     = 4;
    localparam int FIFO_DEPTH = 2;

    localparam logic [MODE_W-1:0] MODE_ZEXT = 4'd0;
    localparam logic [MODE_W-1:0] MODE_SEXT = 4'd1;
    localparam logic [MODE_W-1:0] MODE_LUI  = 4'd2;
    localparam logic [MODE_W-1:0] MODE_BR   = 4'd3;
    localparam logic [MODE_W-1:0] MODE_JMP  = 4'd4;
    localparam logic [MODE_W-1:0] MODE_SHL2 = 4'd5;
    localparam logic [MODE_W-1:0] MODE_LB   = 4'd8;
    localparam logic [MODE_W-1:0] MODE_LBU  = 4'd9;
    localparam logic [MODE_W-1:0] MODE_LH   = 4'd10;
    localparam logic [MODE_W-1:0] MODE_LHU  = 4'd11;

endpackage

// File: rtl/ext_target_unit_if.sv
// ext_target_unit_if: request/result bundle of the extension unit.
//   Request side : in_valid, in_ready, in_mode, in_imm, in_idx, in_pc,
//                  in_word, in_addr_lo
//   Result side  : out_valid, out_ready, out_data, out_err
// Handshake: a beat moves on a rising edge where valid && ready are both 1.
// The producer holds its payload stable while valid && !ready; ready may
// depend combinationally on state but never on the partner's valid.
// Modports: master = the datapath driving requests and taking results,
//           slave  = the unit.
interface ext_target_unit_if
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int IDX_W  = 26
);
    logic              in_valid;
    logic              in_ready;
    logic [MODE_W-1:0] in_mode;
    logic [IMM_W-1:0]  in_imm;
    logic [IDX_W-1:0]  in_idx;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_word;
    logic [1:0]        in_addr_lo;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport master (
        output in_valid, in_mode, in_imm, in_idx, in_pc, in_word, in_addr_lo,
        output out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_mode, in_imm, in_idx, in_pc, in_word, in_addr_lo,
        input  out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/ext_calc.sv
// ext_calc: combinational mode mux, extender and branch-target adder.
// Ports: mode/imm/idx/pc/word/addr_lo in, data/err out.
// Build option: EXT_TARGET_LOAD_EN enables load-lane modes LB/LBU/LH/LHU;
// without it those codes are illegal and word/addr_lo are ignored.
// DATA_W must equal PC_HI_W+IDX_W+2 and be >= IMM_W+2; load lanes assume
// a 32-bit word.
module ext_calc
    import ext_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int IDX_W   = 26,
    parameter int PC_HI_W = 4
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [IMM_W-1:0]  imm,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] data,
    output logic              err
);
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] br_target;

    assign imm_sext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    // Word offset: drop the top two bits of the sign-extended value and
    // append 2'b00, which is the shift-by-two with the carry discarded.
    assign br_target = pc + {imm_sext[DATA_W-3:0], 2'b00};

`ifdef EXT_TARGET_LOAD_EN
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    assign byte_lane = word[{addr_lo, 3'b000} +: 8];
    assign half_lane = addr_lo[1] ? word[31:16] : word[15:0];
`else
    logic unused_load;
    assign unused_load = ^{word, addr_lo};
`endif

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (mode)
            MODE_ZEXT: data = {{(DATA_W-IMM_W){1'b0}}, imm};
            MODE_SEXT: data = imm_sext;
            MODE_LUI:  data = {imm, {(DATA_W-IMM_W){1'b0}}};
            MODE_BR:   data = br_target;
            MODE_JMP:  data = {pc[DATA_W-1 -: PC_HI_W], idx, 2'b00};
            MODE_SHL2: data = {{(DATA_W-IMM_W-2){1'b0}}, imm, 2'b00};
`ifdef EXT_TARGET_LOAD_EN
            MODE_LB:   data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            MODE_LBU:  data = {{(DATA_W-8){1'b0}}, byte_lane};
            MODE_LH: begin
                // Odd byte address cannot hold an aligned halfword.
                if (addr_lo[0]) err = 1'b1;
                else            data = {{(DATA_W-16){half_lane[15]}}, half_lane};
            end
            MODE_LHU: begin
                if (addr_lo[0]) err = 1'b1;
                else            data = {{(DATA_W-16){1'b0}}, half_lane};
            end
`endif
            default:   err = 1'b1;
        endcase
    end
endmodule

// File: rtl/ext_target_unit.sv
// ext_target_unit: operand-extension / branch-jump target unit with a
// 2-entry registered result queue.
// Ports: clk, rst (synchronous, active-high), bus (ext_target_unit_if.slave)
//   carrying the request (in_*) and result (out_*) handshakes.
// Build option: EXT_TARGET_LOAD_EN adds load-lane modes 8..11 (see ext_calc).
// Results appear one cycle after acceptance when the queue was empty;
// illegal modes still enqueue an entry with err set and data zero.
module ext_target_unit
    import ext_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int IDX_W   = 26,
    parameter int PC_HI_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    ext_target_unit_if.slave bus
);
    localparam logic [1:0] COUNT_FULL = 2'(FIFO_DEPTH);

    logic [DATA_W-1:0] calc_data;
    logic              calc_err;

    ext_calc #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .IDX_W  (IDX_W),
        .PC_HI_W(PC_HI_W)
    ) u_calc (
        .mode   (bus.in_mode),
        .imm    (bus.in_imm),
        .idx    (bus.in_idx),
        .pc     (bus.in_pc),
        .word   (bus.in_word),
        .addr_lo(bus.in_addr_lo),
        .data   (calc_data),
        .err    (calc_err)
    );

    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic              q_err  [FIFO_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    assign bus.in_ready  = !rst && (count != COUNT_FULL);
    assign bus.out_valid = (count != 2'd0);
    // Gated so the result bus reads zero whenever the queue is empty.
    assign bus.out_data  = bus.out_valid ? q_data[rd_ptr] : '0;
    assign bus.out_err   = bus.out_valid ? q_err[rd_ptr]  : 1'b0;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Queue storage needs no reset: entries are only visible via count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= calc_data;
                q_err[wr_ptr]  <= calc_err;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ext_target_unit.sv
module tb_ext_target_unit;
    import ext_pkg::*;

    localparam int DATA_W  = 32;
    localparam int IMM_W   = 16;
    localparam int IDX_W   = 26;
    localparam int PC_HI_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ext_target_unit_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .IDX_W(IDX_W)) bus ();

    ext_target_unit #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .IDX_W  (IDX_W),
        .PC_HI_W(PC_HI_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Result = {err, data}, computed with plain arithmetic from the mode rules.
    function automatic logic [32:0] model_calc(input logic [3:0] mode, input logic [15:0] imm,
                                               input logic [25:0] idx, input logic [31:0] pc,
                                               input logic [31:0] word, input logic [1:0] lo);
        int          si;
        logic [31:0] v;
        si = int'($signed(imm));
        case (mode)
            4'd0: return {1'b0, 32'(imm)};
            4'd1: return {1'b0, 32'(si)};
            4'd2: return {1'b0, 32'(imm) << 16};
            4'd3: return {1'b0, pc + 32'(si * 4)};
            4'd4: return {1'b0, (pc & 32'hF000_0000) | (32'(idx) << 2)};
            4'd5: return {1'b0, 32'(imm) * 32'd4};
`ifdef EXT_TARGET_LOAD_EN
            4'd8, 4'd9: begin
                v = (word >> (8 * int'(lo))) & 32'hFF;
                if (mode == 4'd8 && v >= 32'd128) v = v - 32'd256;
                return {1'b0, v};
            end
            4'd10, 4'd11: begin
                if (lo % 2 == 1) return {1'b1, 32'd0};
                v = (word >> (16 * (int'(lo) / 2))) & 32'hFFFF;
                if (mode == 4'd10 && v >= 32'd32768) v = v - 32'd65536;
                return {1'b0, v};
            end
`endif
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    logic        m_pop;
    logic        m_push;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            m_pop  = (exp_q.size() != 0) && bus.out_ready;
            m_push = bus.in_valid && (exp_q.size() != FIFO_DEPTH);
            if (m_pop) void'(exp_q.pop_front());
            if (m_push)
                exp_q.push_back(model_calc(bus.in_mode, bus.in_imm, bus.in_idx, bus.in_pc,
                                           bus.in_word, bus.in_addr_lo));
        end
    end

    // Compare process: every negative edge after the first reset edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("in_ready", 64'(bus.in_ready), 64'(!rst && exp_q.size() != FIFO_DEPTH));
            check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("out_data", 64'(bus.out_data), 64'(exp_q[0][31:0]));
                check("out_err", 64'(bus.out_err), 64'(exp_q[0][32]));
            end else if (rst) begin
                check("rst_data", 64'(bus.out_data), 64'd0);
                check("rst_err", 64'(bus.out_err), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] mode, input logic [15:0] imm, input logic [25:0] idx,
                           input logic [31:0] pc, input logic [31:0] word, input logic [1:0] lo);
        bus.in_valid   = 1'b1;
        bus.in_mode    = mode;
        bus.in_imm     = imm;
        bus.in_idx     = idx;
        bus.in_pc      = pc;
        bus.in_word    = word;
        bus.in_addr_lo = lo;
    endtask

    // One request into an empty queue with out_ready=1; result checked against a literal.
    task automatic do_one(input string name, input logic [3:0] mode, input logic [15:0] imm,
                          input logic [25:0] idx, input logic [31:0] pc, input logic [31:0] word,
                          input logic [1:0] lo, input logic [31:0] exp_d, input logic exp_e);
        tick();
        bus.out_ready = 1'b1;
        set_req(mode, imm, idx, pc, word, lo);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_data"}, 64'(bus.out_data), 64'(exp_d));
        check({name, "_err"}, 64'(bus.out_err), 64'(exp_e));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.out_ready = 1'b1;
        set_req(4'd1, 16'h8001, 26'h0, 32'h0, 32'h0, 2'd0);

        // Reset with a pending request.
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_empty", 64'(bus.out_valid), 64'd0);

        // Pin the model with hand-computed values.
        check("model_sext", 64'(model_calc(4'd1, 16'h8001, 26'h0, 32'h0, 32'h0, 2'd0)), 64'h0_FFFF8001);
        check("model_br", 64'(model_calc(4'd3, 16'hFFFF, 26'h0, 32'h0040_0010, 32'h0, 2'd0)), 64'h0_0040000C);
        check("model_bad", 64'(model_calc(4'hF, 16'h1234, 26'h0, 32'h0, 32'h0, 2'd0)), 64'h1_00000000);

        do_one("sext", 4'd1, 16'h8001, 26'h0, 32'h0, 32'h0, 2'd0, 32'hFFFF8001, 1'b0);
        do_one("zext", 4'd0, 16'h8001, 26'h0, 32'h0, 32'h0, 2'd0, 32'h00008001, 1'b0);
        do_one("lui",  4'd2, 16'h1234, 26'h0, 32'h0, 32'h0, 2'd0, 32'h12340000, 1'b0);
        do_one("br",   4'd3, 16'hFFFF, 26'h0, 32'h0040_0010, 32'h0, 2'd0, 32'h0040000C, 1'b0);
        do_one("jmp",  4'd4, 16'h0, 26'h0000100, 32'hA000_0004, 32'h0, 2'd0, 32'hA0000400, 1'b0);
        do_one("shl2", 4'd5, 16'h8001, 26'h0, 32'h0, 32'h0, 2'd0, 32'h00020004, 1'b0);

        // Back-to-back pushes with the consumer stalled.
        tick();
        bus.out_ready = 1'b0;
        set_req(4'd0, 16'd1, 26'h0, 32'h0, 32'h0, 2'd0);
        tick();
        set_req(4'd0, 16'd2, 26'h0, 32'h0, 32'h0, 2'd0);
        tick();
        set_req(4'd0, 16'd3, 26'h0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_head", 64'(bus.out_data), 64'd1);
        tick();
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("drain_second", 64'(bus.out_data), 64'd2);
        tick();
        @(negedge clk);
        check("drain_empty", 64'(bus.out_valid), 64'd0);

        // Steady push+pop at occupancy one.
        bus.out_ready = 1'b0;
        set_req(4'd0, 16'd99, 26'h0, 32'h0, 32'h0, 2'd0);
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_req(4'd0, 16'(100 + i), 26'h0, 32'h0, 32'h0, 2'd0);
            @(negedge clk);
            check("steady_count1", 64'({bus.out_valid, bus.in_ready}), 64'd3);
            check("steady_head", 64'(bus.out_data), 64'(99 + i));
            tick();
        end
        bus.in_valid = 1'b0;

        do_one("bad_mode", 4'hF, 16'h1234, 26'h3, 32'h1, 32'h1, 2'd0, 32'h0, 1'b1);

`ifdef EXT_TARGET_LOAD_EN
        do_one("lb",  4'd8,  16'h0, 26'h0, 32'h0, 32'h80FF_7F01, 2'd2, 32'hFFFFFFFF, 1'b0);
        do_one("lbu", 4'd9,  16'h0, 26'h0, 32'h0, 32'h80FF_7F01, 2'd3, 32'h00000080, 1'b0);
        do_one("lh",  4'd10, 16'h0, 26'h0, 32'h0, 32'h80FF_7F01, 2'd2, 32'hFFFF80FF, 1'b0);
        do_one("lhu", 4'd11, 16'h0, 26'h0, 32'h0, 32'h80FF_7F01, 2'd1, 32'h00000000, 1'b1);
`else
        do_one("lb_off", 4'd8, 16'h0, 26'h0, 32'h0, 32'h80FF_7F01, 2'd2, 32'h0, 1'b1);
`endif

        // Randomized traffic, occasional mid-stream reset.
        for (int i = 0; i < 800; i++) begin
            tick();
            rst = ($urandom_range(0, 63) == 0);
            set_req(4'($urandom_range(0, 15)), 16'($urandom), 26'($urandom), $urandom, $urandom,
                    2'($urandom_range(0, 3)));
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end

        tick();
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("final_empty", 64'(bus.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
